// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter with a one-cycle done pulse and
// optional periodic reload.
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   start        load load_val and begin counting (honoured in IDLE/DONE)
//   load_val     start/reload value, sampled when start is accepted
//   en           count enable; low while running pauses the count
//   auto_reload  sampled in DONE: reload the latched value and keep running
//   abort        return to IDLE at once, no done pulse
//   cnt_o        current count
//   busy_o       high whenever the timer is not idle
//   done_o       one-cycle pulse on reaching zero
module down_counter_timer #(
  parameter int unsigned CNT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 en,
  input  logic                 auto_reload,
  input  logic                 abort,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] reload_q, reload_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath; priority is abort > start > en/auto_reload
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cnt_d    = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          // start is ignored while running
          if (en) begin
            if (cnt_q > CNT_WIDTH'(1)) begin
              cnt_d = cnt_q - CNT_WIDTH'(1);
            end else begin
              cnt_d   = '0;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (start) begin
            cnt_d    = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? RUN : DONE;
          end else if (auto_reload && (reload_q != '0)) begin
            cnt_d   = reload_q;
            state_d = RUN;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Count, reload value and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      reload_q <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      busy_o   <= (state_d != IDLE);
      done_o   <= (state_d == DONE);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

  localparam int unsigned W = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] load_val;
  logic         en;
  logic         auto_reload;
  logic         abort;
  logic [W-1:0] cnt_o;
  logic         busy_o;
  logic         done_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: remaining count, whether a countdown is in progress,
  // whether this cycle is the terminal pulse, and the period to reuse.
  int m_cnt    = 0;
  int m_reload = 0;
  bit m_active = 1'b0;
  bit m_pulse  = 1'b0;
  int pulses   = 0;

  down_counter_timer #(.CNT_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .abort       (abort),
    .cnt_o       (cnt_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_reload = 0;
    m_active = 1'b0;
    m_pulse  = 1'b0;
  endtask

  // Apply the timer rules for one clock edge using the inputs present at it.
  task automatic model_edge();
    if (abort) begin
      model_reset_keep_reload();
    end else if (!m_active && start) begin
      m_cnt    = int'(load_val);
      m_reload = int'(load_val);
      m_active = (load_val != 0);
      m_pulse  = (load_val == 0);
    end else if (m_pulse) begin
      m_pulse = 1'b0;
      if (auto_reload && m_reload != 0) begin
        m_cnt    = m_reload;
        m_active = 1'b1;
      end else begin
        m_cnt = 0;
      end
    end else if (m_active && en) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_active = 1'b0;
        m_pulse  = 1'b1;
      end
    end
  endtask

  task automatic model_reset_keep_reload();
    m_cnt    = 0;
    m_active = 1'b0;
    m_pulse  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cnt"},  32'(cnt_o),  32'(m_cnt));
    check({tag, ".busy"}, 32'(busy_o), 32'(m_active || m_pulse));
    check({tag, ".done"}, 32'(done_o), 32'(m_pulse));
  endtask

  // One clock: edge, model update, settled check; inputs change only after.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    if (done_o) pulses++;
  endtask

  task automatic drive(input bit s, input int lv, input bit e, input bit ar, input bit ab);
    start       = s;
    load_val    = W'(lv);
    en          = e;
    auto_reload = ar;
    abort       = ab;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    check("reset.cnt", 32'(cnt_o), 0);
    check("reset.busy", 32'(busy_o), 0);
    check("reset.done", 32'(done_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: load 5, count to zero, single pulse, then idle
    drive(1, 5, 1, 0, 0);
    cycle("t1.load");
    check("t1.first", 32'(cnt_o), 5);
    drive(0, 0, 1, 0, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) cycle("t1.run");
    check("t1.pulses", 32'(pulses), 1);
    check("t1.idle_busy", 32'(busy_o), 0);

    // 2: pause with en
    drive(1, 3, 1, 0, 0);
    cycle("t2.load");
    pulses = 0;
    drive(0, 0, 1, 0, 0); cycle("t2.e1");
    drive(0, 0, 0, 0, 0); cycle("t2.e0");
    cycle("t2.e0b");
    check("t2.hold", 32'(cnt_o), 2);
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle("t2.run");
    check("t2.pulses", 32'(pulses), 1);

    // 3: auto reload period of N+1
    drive(1, 4, 1, 1, 0);
    pulses = 0;
    cycle("t3.load");
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 14; i++) cycle("t3.run");
    check("t3.pulses", 32'(pulses), 3);
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle("t3.drop");
    check("t3.idle", 32'(busy_o), 0);

    // 4a: zero load goes straight to the pulse
    drive(1, 0, 1, 0, 0);
    cycle("t4.zero");
    check("t4.zero_done", 32'(done_o), 1);
    drive(0, 0, 1, 0, 0);
    cycle("t4.after");
    check("t4.after_done", 32'(done_o), 0);

    // 4b: start while running is ignored
    drive(1, 9, 1, 0, 0);
    cycle("t4.load9");
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle("t4.run");
    drive(1, 9, 1, 0, 0);
    cycle("t4.restart");
    check("t4.ignored", 32'(cnt_o), 5);
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle("t4.tail");

    // 5: abort together with start at cnt 1
    drive(1, 3, 1, 0, 0);
    cycle("t5.load");
    drive(0, 0, 1, 0, 0);
    cycle("t5.r2");
    cycle("t5.r1");
    pulses = 0;
    drive(1, 7, 1, 0, 1);
    cycle("t5.abort");
    drive(0, 0, 1, 0, 0);
    cycle("t5.post");
    check("t5.no_pulse", 32'(pulses), 0);

    // 6: asynchronous reset mid-run, then a full-scale count
    drive(1, 100, 1, 0, 0);
    cycle("t6.load");
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 50; i++) cycle("t6.run");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    m_reload = 0;
    check("t6.async_cnt", 32'(cnt_o), 0);
    check("t6.async_busy", 32'(busy_o), 0);
    check("t6.async_done", 32'(done_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 127, 1, 0, 0);
    cycle("t6.load127");
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 127; i++) cycle("t6.full");
    check("t6.full_done", 32'(done_o), 1);
    cycle("t6.end");

    // Random mix against the reference
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 6) == 0,
            (($urandom % 8) == 0) ? int'($urandom % 128) : int'($urandom % 12),
            ($urandom % 4) != 0,
            ($urandom % 2) == 1,
            ($urandom % 25) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop so the run always ends
  initial begin
    #200000;
    $error("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
